ptw_mem_arbiter: RTL

PTW_MEM_ARBITER -- requirements
Module: ptw_mem_arbiter

---
 rtl/ptw_mem_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ptw_mem_arbiter.sv
// Shares one RAM read port between the IMEM and DMEM page-table walkers.
// Round-robin grant, range-checked single-word reads, one response per walk.
module ptw_mem_arbiter #(
   parameter logic [31:0] RAM_BASE = 32'h8000_0000,
   parameter int unsigned MEMSIZE  = 50000000,
   parameter int unsigned RD_LAT   = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   input  logic [31:0] addr_i,
   input  logic        abort_i,
   output logic        resp_i,
   output logic [31:0] word_i,
   output logic        err_i,
   input  logic        req_d,
   input  logic [31:0] addr_d,
   input  logic        abort_d,
   output logic        resp_d,
   output logic [31:0] word_d,
   output logic        err_d,
   output logic        mem_re,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic        owner
);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_GAP} state_t;

   // 33-bit bounds so the end of a RAM near 4 GiB cannot wrap to zero
   localparam logic [32:0] RAM_LO = {1'b0, RAM_BASE};
   localparam logic [32:0] RAM_HI = RAM_LO + (33'(MEMSIZE) << 2);
   localparam logic [2:0]  LAT    = 3'(RD_LAT);

   state_t      state_q;
   logic        owner_q;
   logic        rr_q;
   logic        busy_q;
   logic        ok_q;
   logic        kill_q;
   logic [2:0]  cnt_q;
   logic        mem_re_q;
   logic [31:0] mem_addr_q;
   logic        resp_i_q;
   logic        resp_d_q;
   logic [31:0] word_i_q;
   logic [31:0] word_d_q;
   logic        err_i_q;
   logic        err_d_q;

   logic        gnt_sel;
   logic [31:0] gnt_addr;
   logic [32:0] gnt_waddr;
   logic        gnt_ok;
   logic        kill;
   logic        ld_en;
   logic [31:0] ld_word;
   logic        ld_err;

   always_comb begin
      gnt_sel   = (req_i && req_d) ? rr_q : req_d;
      gnt_addr  = gnt_sel ? addr_d : addr_i;
      gnt_waddr = {1'b0, gnt_addr[31:2], 2'b00};
      gnt_ok    = (gnt_waddr >= RAM_LO) && (gnt_waddr < RAM_HI);
      // only an abort from the owner, while it still requests, cancels the reply
      kill      = kill_q || (owner_q ? (req_d && abort_d) : (req_i && abort_i));
      ld_en     = 1'b0;
      ld_word   = 32'h0;
      ld_err    = 1'b0;
      if (state_q == S_ISSUE && !ok_q) begin
         ld_en  = !kill;
         ld_err = 1'b1;
      end else if (state_q == S_WAIT && cnt_q == LAT) begin
         ld_en   = !kill;
         ld_word = mem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         owner_q    <= 1'b0;
         rr_q       <= 1'b0;
         busy_q     <= 1'b0;
         ok_q       <= 1'b0;
         kill_q     <= 1'b0;
         cnt_q      <= 3'd0;
         mem_re_q   <= 1'b0;
         mem_addr_q <= 32'h0;
         resp_i_q   <= 1'b0;
         resp_d_q   <= 1'b0;
         word_i_q   <= 32'h0;
         word_d_q   <= 32'h0;
         err_i_q    <= 1'b0;
         err_d_q    <= 1'b0;
      end else begin
         mem_re_q   <= 1'b0;
         mem_addr_q <= 32'h0;
         resp_i_q   <= 1'b0;
         resp_d_q   <= 1'b0;
         if (ld_en) begin
            if (owner_q) begin
               resp_d_q <= 1'b1;
               word_d_q <= ld_word;
               err_d_q  <= ld_err;
            end else begin
               resp_i_q <= 1'b1;
               word_i_q <= ld_word;
               err_i_q  <= ld_err;
            end
         end
         case (state_q)
            S_IDLE: begin
               if (req_i || req_d) begin
                  state_q  <= S_ISSUE;
                  owner_q  <= gnt_sel;
                  rr_q     <= !gnt_sel;
                  busy_q   <= 1'b1;
                  ok_q     <= gnt_ok;
                  kill_q   <= 1'b0;
                  // strobe is registered here so it lands in the ISSUE cycle
                  mem_re_q <= gnt_ok;
                  if (gnt_ok) mem_addr_q <= (gnt_addr - RAM_BASE) >> 2;
               end
            end
            S_ISSUE: begin
               kill_q <= kill;
               if (ok_q) begin
                  cnt_q   <= 3'd1;
                  state_q <= S_WAIT;
               end else begin
                  state_q <= S_RESP;
               end
            end
            S_WAIT: begin
               kill_q <= kill;
               if (cnt_q == LAT) begin
                  cnt_q   <= 3'd0;
                  state_q <= S_RESP;
               end else begin
                  cnt_q <= cnt_q + 3'd1;
               end
            end
            S_RESP: state_q <= S_GAP;
            S_GAP: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               ok_q    <= 1'b0;
               kill_q  <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign resp_i   = resp_i_q;
   assign word_i   = word_i_q;
   assign err_i    = err_i_q;
   assign resp_d   = resp_d_q;
   assign word_d   = word_d_q;
   assign err_d    = err_d_q;
   assign mem_re   = mem_re_q;
   assign mem_addr = mem_addr_q;
   assign busy     = busy_q;
   assign owner    = owner_q;

endmodule
